// File: rtl/ahb3lite_interconnect_master_port.sv
// Master-side port of the AHB-Lite interconnect: address decode, grant wait with replay, response mux.
// Zero added latency when granted; stalls the master (HREADYOUT=0) while the target port has not granted it.
module ahb3lite_interconnect_master_port #(
    parameter int HADDR_SIZE = 32,
    parameter int HDATA_SIZE = 32,
    parameter int SLAVES     = 8
) (
    input  logic                  HRESETn,
    input  logic                  HCLK,

    input  logic                  mstHSEL,
    input  logic [HADDR_SIZE-1:0] mstHADDR,
    input  logic [HDATA_SIZE-1:0] mstHWDATA,
    input  logic                  mstHWRITE,
    input  logic [2:0]            mstHSIZE,
    input  logic [2:0]            mstHBURST,
    input  logic [3:0]            mstHPROT,
    input  logic [1:0]            mstHTRANS,
    input  logic                  mstHMASTLOCK,
    input  logic                  mstHREADY,
    output logic [HDATA_SIZE-1:0] mstHRDATA,
    output logic                  mstHREADYOUT,
    output logic                  mstHRESP,

    input  logic [HADDR_SIZE-1:0] slvHADDRbase [SLAVES],
    input  logic [HADDR_SIZE-1:0] slvHADDRmask [SLAVES],

    output logic [SLAVES-1:0]     slvHSEL,
    output logic [HADDR_SIZE-1:0] slvHADDR,
    output logic [HDATA_SIZE-1:0] slvHWDATA,
    output logic                  slvHWRITE,
    output logic [2:0]            slvHSIZE,
    output logic [2:0]            slvHBURST,
    output logic [3:0]            slvHPROT,
    output logic [1:0]            slvHTRANS,
    output logic                  slvHMASTLOCK,
    output logic                  slvHREADY,
    input  logic [HDATA_SIZE-1:0] slvHRDATA [SLAVES],
    input  logic [SLAVES-1:0]     slvHREADYOUT,
    input  logic [SLAVES-1:0]     slvHRESP,
    input  logic [SLAVES-1:0]     slvgranted,
    output logic [SLAVES-1:0]     can_switch
);

    localparam int SLAVE_BITS = (SLAVES == 1) ? 1 : $clog2(SLAVES);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    typedef enum logic [1:0] {ST_PASS, ST_WAIT, ST_ERR1, ST_ERR2} state_t;

    typedef struct packed {
        logic [HADDR_SIZE-1:0] addr;
        logic                  write;
        logic [2:0]            size;
        logic [2:0]            burst;
        logic [3:0]            prot;
        logic [1:0]            trans;
        logic                  lock;
    } ap_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [SLAVES-1:0]     r_dp_sel;
    logic [SLAVES-1:0]     w_dp_sel_nxt;
    logic [SLAVES-1:0]     r_pend_sel;
    ap_t                   r_pend;
    ap_t                   w_mst_ap;
    ap_t                   w_eff;
    logic                  w_latch;

    logic [SLAVES-1:0]     w_match;
    logic [SLAVES-1:0]     w_decode;
    logic [SLAVE_BITS-1:0] w_dp_idx;
    logic                  w_dp_any;
    logic                  w_slv_hready;
    logic                  w_accept;
    logic                  w_active;
    logic                  w_dec_go;
    logic                  w_pend_go;
    logic                  w_can_switch;

    // Address decode; a zero mask disables the port, lowest matching index wins.
    always_comb begin
        w_match = '0;
        for (int s = 0; s < SLAVES; s++) begin
            w_match[s] = (|slvHADDRmask[s]) &&
                         ((mstHADDR & slvHADDRmask[s]) == (slvHADDRbase[s] & slvHADDRmask[s]));
        end
    end

    assign w_decode = w_match & (~w_match + SLAVES'(1));

    always_comb begin
        w_dp_idx = '0;
        for (int s = 0; s < SLAVES; s++) begin
            if (r_dp_sel[s]) w_dp_idx = SLAVE_BITS'(s);
        end
    end

    assign w_dp_any     = |r_dp_sel;
    assign w_slv_hready = w_dp_any ? slvHREADYOUT[w_dp_idx] : 1'b1;
    assign slvHREADY    = w_slv_hready;
    assign mstHRDATA    = w_dp_any ? slvHRDATA[w_dp_idx] : '0;

    always_comb begin
        mstHREADYOUT = w_slv_hready;
        mstHRESP     = w_dp_any ? slvHRESP[w_dp_idx] : 1'b0;
        case (r_state)
            ST_WAIT: begin mstHREADYOUT = 1'b0; mstHRESP = 1'b0; end
            ST_ERR1: begin mstHREADYOUT = 1'b0; mstHRESP = 1'b1; end
            ST_ERR2: begin mstHREADYOUT = 1'b1; mstHRESP = 1'b1; end
            default: ;
        endcase
    end

    assign w_accept  = mstHSEL & mstHREADY & mstHREADYOUT;
    assign w_active  = mstHTRANS[1];
    assign w_dec_go  = |(w_decode & slvgranted & slvHREADYOUT);
    assign w_pend_go = |(r_pend_sel & slvgranted & slvHREADYOUT);

    always_comb begin
        w_state_nxt  = r_state;
        w_dp_sel_nxt = '0;
        w_latch      = 1'b0;
        case (r_state)
            ST_PASS, ST_ERR2: begin
                w_state_nxt = ST_PASS;
                if (w_accept && w_active) begin
                    if (w_decode == '0) begin
                        w_state_nxt = ST_ERR1;
                    end else if (w_dec_go) begin
                        w_dp_sel_nxt = w_decode;
                    end else begin
                        w_state_nxt = ST_WAIT;
                        w_latch     = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (w_pend_go) begin
                    w_state_nxt  = ST_PASS;
                    w_dp_sel_nxt = r_pend_sel;
                end
            end
            ST_ERR1: w_state_nxt = ST_ERR2;
            default: w_state_nxt = ST_PASS;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state    <= ST_PASS;
            r_dp_sel   <= '0;
            r_pend_sel <= '0;
            r_pend     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_slv_hready) r_dp_sel <= w_dp_sel_nxt;
            if (w_latch) begin
                r_pend_sel <= w_decode;
                r_pend     <= w_mst_ap;
            end
        end
    end

    assign w_mst_ap = '{addr:  mstHADDR,  write: mstHWRITE, size: mstHSIZE,
                        burst: mstHBURST, prot:  mstHPROT,  trans: mstHTRANS,
                        lock:  mstHMASTLOCK};

    // A replayed SEQ beat becomes NONSEQ: the slave port never saw the burst start.
    always_comb begin
        w_eff   = w_mst_ap;
        slvHSEL = w_decode & {SLAVES{mstHSEL}};
        case (r_state)
            ST_WAIT: begin
                w_eff   = r_pend;
                slvHSEL = r_pend_sel;
                if (r_pend.trans == HTRANS_SEQ) w_eff.trans = HTRANS_NONSEQ;
            end
            ST_ERR1: begin
                w_eff.trans = HTRANS_IDLE;
                slvHSEL     = '0;
            end
            default: ;
        endcase
    end

    assign slvHADDR     = w_eff.addr;
    assign slvHWRITE    = w_eff.write;
    assign slvHSIZE     = w_eff.size;
    assign slvHBURST    = w_eff.burst;
    assign slvHPROT     = w_eff.prot;
    assign slvHTRANS    = w_eff.trans;
    assign slvHMASTLOCK = w_eff.lock;
    assign slvHWDATA    = mstHWDATA;

    assign w_can_switch = ~w_eff.lock & ((w_eff.trans == HTRANS_IDLE) || (w_eff.trans == HTRANS_NONSEQ));
    assign can_switch   = {SLAVES{w_can_switch}};

endmodule

// File: tb/tb_ahb3lite_interconnect_master_port.sv
// Directed bench for the interconnect master port: decode table plus grant-wait, error and reset sequences.
module tb_ahb3lite_interconnect_master_port;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NS = 8;

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] BUSY   = 2'b01;
    localparam logic [1:0] NONSEQ = 2'b10;
    localparam logic [1:0] SEQ    = 2'b11;

    logic          HRESETn = 1'b0;
    logic          HCLK    = 1'b0;
    logic          mstHSEL, mstHWRITE, mstHMASTLOCK, mstHREADY;
    logic [AW-1:0] mstHADDR;
    logic [DW-1:0] mstHWDATA;
    logic [2:0]    mstHSIZE, mstHBURST;
    logic [3:0]    mstHPROT;
    logic [1:0]    mstHTRANS;
    logic [DW-1:0] mstHRDATA;
    logic          mstHREADYOUT, mstHRESP;
    logic [AW-1:0] slvHADDRbase [NS];
    logic [AW-1:0] slvHADDRmask [NS];
    logic [NS-1:0] slvHSEL;
    logic [AW-1:0] slvHADDR;
    logic [DW-1:0] slvHWDATA;
    logic          slvHWRITE, slvHMASTLOCK, slvHREADY;
    logic [2:0]    slvHSIZE, slvHBURST;
    logic [3:0]    slvHPROT;
    logic [1:0]    slvHTRANS;
    logic [DW-1:0] slvHRDATA [NS];
    logic [NS-1:0] slvHREADYOUT, slvHRESP, slvgranted, can_switch;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic          sel;
        logic [AW-1:0] addr;
        logic [1:0]    trans;
        logic          lock;
        logic [NS-1:0] exp_hsel;
        logic [NS-1:0] exp_cs;
    } vec_t;

    vec_t vec [8];

    ahb3lite_interconnect_master_port #(.HADDR_SIZE(AW), .HDATA_SIZE(DW), .SLAVES(NS)) dut (
        .HRESETn(HRESETn), .HCLK(HCLK),
        .mstHSEL(mstHSEL), .mstHADDR(mstHADDR), .mstHWDATA(mstHWDATA), .mstHWRITE(mstHWRITE),
        .mstHSIZE(mstHSIZE), .mstHBURST(mstHBURST), .mstHPROT(mstHPROT), .mstHTRANS(mstHTRANS),
        .mstHMASTLOCK(mstHMASTLOCK), .mstHREADY(mstHREADY),
        .mstHRDATA(mstHRDATA), .mstHREADYOUT(mstHREADYOUT), .mstHRESP(mstHRESP),
        .slvHADDRbase(slvHADDRbase), .slvHADDRmask(slvHADDRmask),
        .slvHSEL(slvHSEL), .slvHADDR(slvHADDR), .slvHWDATA(slvHWDATA), .slvHWRITE(slvHWRITE),
        .slvHSIZE(slvHSIZE), .slvHBURST(slvHBURST), .slvHPROT(slvHPROT), .slvHTRANS(slvHTRANS),
        .slvHMASTLOCK(slvHMASTLOCK), .slvHREADY(slvHREADY),
        .slvHRDATA(slvHRDATA), .slvHREADYOUT(slvHREADYOUT), .slvHRESP(slvHRESP),
        .slvgranted(slvgranted), .can_switch(can_switch)
    );

    always #5 HCLK = ~HCLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic sel, input logic rdy, input logic [AW-1:0] addr,
                         input logic [1:0] trans, input logic wr, input logic lock,
                         input logic [DW-1:0] wdata);
        mstHSEL      = sel;
        mstHREADY    = rdy;
        mstHADDR     = addr;
        mstHTRANS    = trans;
        mstHWRITE    = wr;
        mstHMASTLOCK = lock;
        mstHWDATA    = wdata;
        mstHSIZE     = 3'b010;
        mstHBURST    = 3'b000;
        mstHPROT     = 4'b0011;
    endtask

    task automatic next_cycle();
        @(posedge HCLK);
        #1;
    endtask

    initial begin
        drive(1'b0, 1'b1, '0, IDLE, 1'b0, 1'b0, '0);
        for (int s = 0; s < NS; s++) begin
            slvHADDRbase[s] = '0;
            slvHADDRmask[s] = '0;
            slvHRDATA[s]    = 32'hD000_0000 + 32'(s);
        end
        slvHADDRbase[1] = 32'h1000_0000; slvHADDRmask[0] = 32'hF000_0000;
        slvHADDRmask[1] = 32'hF000_0000;
        slvHADDRbase[2] = 32'h2000_0000; slvHADDRmask[2] = 32'hF000_0000;
        slvHADDRbase[3] = 32'h1000_0000; slvHADDRmask[3] = 32'hFF00_0000;
        slvHADDRbase[4] = 32'h3000_0000;
        slvHREADYOUT = '1;
        slvHRESP     = '0;
        slvgranted   = '1;

        vec[0] = '{1'b1, 32'h1000_0004, NONSEQ, 1'b0, 8'h02, 8'hFF};
        vec[1] = '{1'b1, 32'h0000_1234, SEQ,    1'b0, 8'h01, 8'h00};
        vec[2] = '{1'b1, 32'h2FFF_FFFC, NONSEQ, 1'b1, 8'h04, 8'h00};
        vec[3] = '{1'b1, 32'hF000_0000, IDLE,   1'b0, 8'h00, 8'hFF};
        vec[4] = '{1'b0, 32'h1000_0000, NONSEQ, 1'b0, 8'h00, 8'hFF};
        vec[5] = '{1'b1, 32'h2000_0000, BUSY,   1'b0, 8'h04, 8'h00};
        vec[6] = '{1'b1, 32'h1000_0000, IDLE,   1'b1, 8'h02, 8'h00};
        vec[7] = '{1'b1, 32'h3000_0000, NONSEQ, 1'b0, 8'h00, 8'hFF};

        #3;
        check("reset hreadyout", 64'(mstHREADYOUT), 64'd1);
        check("reset hresp",     64'(mstHRESP),     64'd0);
        check("reset hsel",      64'(slvHSEL),      64'd0);
        check("reset slvhready", 64'(slvHREADY),    64'd1);
        @(negedge HCLK);
        HRESETn = 1'b1;

        // Decode / can_switch table; mstHREADY low so nothing is accepted.
        for (int i = 0; i < 8; i++) begin
            next_cycle();
            drive(vec[i].sel, 1'b0, vec[i].addr, vec[i].trans, 1'b0, vec[i].lock, '0);
            @(negedge HCLK);
            check($sformatf("vec%0d hsel", i),   64'(slvHSEL),    64'(vec[i].exp_hsel));
            check($sformatf("vec%0d cansw", i),  64'(can_switch), 64'(vec[i].exp_cs));
            check($sformatf("vec%0d htrans", i), 64'(slvHTRANS),  64'(vec[i].trans));
            check($sformatf("vec%0d haddr", i),  64'(slvHADDR),   64'(vec[i].addr));
        end

        // Granted read to slave 1.
        next_cycle();
        drive(1'b1, 1'b1, 32'h1000_0004, NONSEQ, 1'b0, 1'b0, '0);
        @(negedge HCLK);
        check("rd hsel",  64'(slvHSEL),      64'h02);
        check("rd ready", 64'(mstHREADYOUT), 64'd1);
        next_cycle();
        drive(1'b1, 1'b1, 32'h1000_0004, IDLE, 1'b0, 1'b0, '0);
        @(negedge HCLK);
        check("rd data",  64'(mstHRDATA),    64'hD000_0001);
        check("rd dp ready", 64'(mstHREADYOUT), 64'd1);
        #1 slvHREADYOUT[1] = 1'b0;
        #1;
        check("rd stall ready",    64'(mstHREADYOUT), 64'd0);
        check("rd stall slvready", 64'(slvHREADY),    64'd0);
        slvHREADYOUT[1] = 1'b1;

        // Read held for grant: address phase then four WAIT cycles.
        next_cycle();
        slvgranted[1] = 1'b0;
        drive(1'b1, 1'b1, 32'h1000_0004, NONSEQ, 1'b0, 1'b0, '0);
        @(negedge HCLK);
        check("wt addr ready", 64'(mstHREADYOUT), 64'd1);
        next_cycle();
        drive(1'b1, 1'b1, 32'h2000_0000, IDLE, 1'b0, 1'b0, '0);
        for (int w = 0; w < 4; w++) begin
            if (w == 3) slvgranted[1] = 1'b1;
            @(negedge HCLK);
            check($sformatf("wt%0d ready", w),  64'(mstHREADYOUT), 64'd0);
            check($sformatf("wt%0d hsel", w),   64'(slvHSEL),      64'h02);
            check($sformatf("wt%0d haddr", w),  64'(slvHADDR),     64'h1000_0004);
            check($sformatf("wt%0d htrans", w), 64'(slvHTRANS),    64'(NONSEQ));
            next_cycle();
        end
        @(negedge HCLK);
        check("wt data",  64'(mstHRDATA),    64'hD000_0001);
        check("wt ready", 64'(mstHREADYOUT), 64'd1);

        // SEQ write replayed as NONSEQ.
        next_cycle();
        slvgranted[2] = 1'b0;
        drive(1'b1, 1'b1, 32'h2000_0010, SEQ, 1'b1, 1'b0, 32'hCAFE_BABE);
        @(negedge HCLK);
        check("sq pass htrans", 64'(slvHTRANS), 64'(SEQ));
        next_cycle();
        slvgranted[2] = 1'b1;
        @(negedge HCLK);
        check("sq wait htrans", 64'(slvHTRANS),    64'(NONSEQ));
        check("sq wait hwrite", 64'(slvHWRITE),    64'd1);
        check("sq wait hwdata", 64'(slvHWDATA),    64'hCAFE_BABE);
        check("sq wait hsel",   64'(slvHSEL),      64'h04);
        check("sq wait ready",  64'(mstHREADYOUT), 64'd0);
        next_cycle();
        drive(1'b1, 1'b1, 32'h2000_0010, IDLE, 1'b0, 1'b0, 32'hCAFE_BABE);
        @(negedge HCLK);
        check("sq dp ready",  64'(mstHREADYOUT), 64'd1);
        check("sq dp hwdata", 64'(slvHWDATA),    64'hCAFE_BABE);
        check("sq dp data",   64'(mstHRDATA),    64'hD000_0002);

        // Unmapped NONSEQ: two-cycle ERROR response.
        next_cycle();
        drive(1'b1, 1'b1, 32'hF000_0000, NONSEQ, 1'b0, 1'b0, '0);
        @(negedge HCLK);
        check("er hsel", 64'(slvHSEL), 64'd0);
        next_cycle();
        drive(1'b1, 1'b1, 32'hF000_0000, IDLE, 1'b0, 1'b0, '0);
        @(negedge HCLK);
        check("er1 rdy/resp", 64'({mstHREADYOUT, mstHRESP}), 64'b01);
        check("er1 hsel",     64'(slvHSEL),                  64'd0);
        next_cycle();
        @(negedge HCLK);
        check("er2 rdy/resp", 64'({mstHREADYOUT, mstHRESP}), 64'b11);
        next_cycle();
        @(negedge HCLK);
        check("er done rdy/resp", 64'({mstHREADYOUT, mstHRESP}), 64'b10);

        // IDLE to unmapped address: zero-wait OKAY.
        next_cycle();
        @(negedge HCLK);
        check("idle unmapped rdy/resp", 64'({mstHREADYOUT, mstHRESP}), 64'b10);

        // Reset asserted mid-WAIT.
        next_cycle();
        slvgranted[1] = 1'b0;
        drive(1'b1, 1'b1, 32'h1000_0004, NONSEQ, 1'b0, 1'b0, '0);
        next_cycle();
        @(negedge HCLK);
        check("rs wait ready", 64'(mstHREADYOUT), 64'd0);
        #1;
        HRESETn = 1'b0;
        drive(1'b0, 1'b1, '0, IDLE, 1'b0, 1'b0, '0);
        #1;
        check("rs hsel",  64'(slvHSEL),      64'd0);
        check("rs ready", 64'(mstHREADYOUT), 64'd1);
        check("rs resp",  64'(mstHRESP),     64'd0);
        next_cycle();
        HRESETn = 1'b1;
        slvgranted[1] = 1'b1;
        drive(1'b1, 1'b1, 32'h1000_0004, NONSEQ, 1'b0, 1'b0, '0);
        @(negedge HCLK);
        check("rs post hsel",  64'(slvHSEL),      64'h02);
        check("rs post ready", 64'(mstHREADYOUT), 64'd1);
        next_cycle();
        drive(1'b1, 1'b1, 32'h1000_0004, IDLE, 1'b0, 1'b0, '0);
        @(negedge HCLK);
        check("rs post data", 64'(mstHRDATA), 64'hD000_0001);

        next_cycle();
        drive(1'b0, 1'b1, '0, IDLE, 1'b0, 1'b0, '0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
